// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side frame parser.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } parser_state_t;

    typedef enum logic [1:0] {
        ERR_LEN     = 2'b00,
        ERR_CHK     = 2'b01,
        ERR_PARITY  = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/uart_frame_parser_frame_buf.sv
// Payload buffer: register array with a synchronous write port and a combinational read port.
module frame_buf #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Pops bytes from the UART RX FIFO, assembles SOF/LEN/payload/CHK frames and
// releases checksum-verified payloads on a valid/ready stream.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int unsigned       DATA_W         = 8,
    parameter int unsigned       MAX_LEN        = 16,
    parameter logic [DATA_W-1:0] SOF            = DATA_W'(DEFAULT_SOF),
    parameter int unsigned       TIMEOUT_CYCLES = 230_000,
    parameter int unsigned       LEN_W          = $clog2(MAX_LEN + 1),
    parameter int unsigned       TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              rx_empty,
    input  logic [DATA_W-1:0] r_data,
    input  logic              parity_err,
    output logic              rd_uart,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [LEN_W-1:0]  frame_len,
    output logic              err_valid,
    output logic [1:0]        err_code
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    parser_state_t     state, state_nxt;
    logic [LEN_W-1:0]  wr_ptr, rd_ptr, frame_len_q;
    logic [DATA_W-1:0] acc;
    logic [TO_W-1:0]   to_cnt;
    logic              err_valid_q;
    err_code_t         err_code_q;

    logic              err_set;
    err_code_t         err_nxt;
    logic              pop, accept, counting, timeout;
    logic              len_ok, payload_done, last_byte, payload_we;
    logic [DATA_W-1:0] buf_rdata;

    assign pop          = rd_uart;
    assign accept       = pop && !parity_err;
    assign counting     = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    assign timeout      = counting && !pop && (to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign len_ok       = (r_data != '0) && (r_data <= DATA_W'(MAX_LEN));
    assign payload_done = (wr_ptr + LEN_W'(1)) == frame_len_q;
    assign last_byte    = rd_ptr == (frame_len_q - LEN_W'(1));
    assign payload_we   = (state == ST_PAYLOAD) && accept;

    frame_buf #(
        .DEPTH  (MAX_LEN),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_frame_buf (
        .clk   (clk),
        .we    (payload_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (r_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Parity outranks the per-state checks; a pop outranks the timeout.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_nxt   = ERR_LEN;
        case (state)
            ST_HUNT: begin
                if (pop && (r_data == SOF)) begin
                    state_nxt = ST_LEN;
                end
            end
            ST_LEN, ST_PAYLOAD, ST_CHK: begin
                if (pop) begin
                    if (parity_err) begin
                        err_set   = 1'b1;
                        err_nxt   = ERR_PARITY;
                        state_nxt = ST_HUNT;
                    end else if (state == ST_LEN) begin
                        if (len_ok) begin
                            state_nxt = ST_PAYLOAD;
                        end else begin
                            err_set   = 1'b1;
                            err_nxt   = ERR_LEN;
                            state_nxt = ST_HUNT;
                        end
                    end else if (state == ST_PAYLOAD) begin
                        if (payload_done) begin
                            state_nxt = ST_CHK;
                        end
                    end else if (r_data == acc) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        err_set   = 1'b1;
                        err_nxt   = ERR_CHK;
                        state_nxt = ST_HUNT;
                    end
                end else if (timeout) begin
                    err_set   = 1'b1;
                    err_nxt   = ERR_TIMEOUT;
                    state_nxt = ST_HUNT;
                end
            end
            ST_DRAIN: begin
                if (m_ready && last_byte) begin
                    state_nxt = ST_HUNT;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_len_q <= '0;
            acc         <= '0;
            to_cnt      <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_LEN;
        end else begin
            err_valid_q <= err_set;
            if (err_set) begin
                err_code_q <= err_nxt;
            end
            if (!counting || pop || timeout) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if ((state == ST_LEN) && accept && len_ok) begin
                frame_len_q <= LEN_W'(r_data);
                acc         <= r_data;
                wr_ptr      <= '0;
            end
            if (payload_we) begin
                wr_ptr <= wr_ptr + LEN_W'(1);
                acc    <= acc ^ r_data;
            end
            if ((state == ST_CHK) && accept && (r_data == acc)) begin
                rd_ptr <= '0;
            end
            if ((state == ST_DRAIN) && m_ready) begin
                rd_ptr <= rd_ptr + LEN_W'(1);
            end
        end
    end

    // Pop is gated by reset so nothing leaves the FIFO while the parser is held.
    always_comb begin
        rd_uart = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        if (!Reset) begin
            rd_uart = !rx_empty && (state != ST_DRAIN);
        end
        if (state == ST_DRAIN) begin
            m_valid = 1'b1;
            m_data  = buf_rdata;
            m_last  = last_byte;
        end
    end

    assign frame_len = frame_len_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench: FIFO model feeding the parser, frame-level reference model and directed tests.
`timescale 1ns/1ps
module tb_uart_frame_parser;
    import uart_pkg::*;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TO      = 40;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  SOF_B   = 8'hA5;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             rx_empty = 1'b1;
    logic [7:0]       r_data = 8'h00;
    logic             parity_err = 1'b0;
    logic             m_ready = 1'b0;
    logic             rd_uart, m_valid, m_last, err_valid;
    logic [7:0]       m_data;
    logic [LEN_W-1:0] frame_len;
    logic [1:0]       err_code;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .DATA_W         (8),
        .MAX_LEN        (MAX_LEN),
        .SOF            (SOF_B),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .parity_err (parity_err),
        .rd_uart    (rd_uart),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .frame_len  (frame_len),
        .err_valid  (err_valid),
        .err_code   (err_code)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    logic [8:0]  fifo[$];          // {parity, byte}
    logic [8:0]  out_log[$];       // {last, data}
    logic [1:0]  err_log[$];
    int unsigned err_cyc = 0;
    int unsigned last_pop_edge = 0;

    // Reference model state: frame-level view of the byte stream
    bit               in_frame = 0;
    logic [7:0]       cur[$];      // LEN byte followed by payload collected so far
    int unsigned      lenv = 0;
    int unsigned      since = 0;
    logic [7:0]       drain_q[$];
    logic [LEN_W-1:0] exp_len = '0;
    bit               err_pend = 0;
    logic [1:0]       err_pend_code = 2'b00;

    bit   ready_force = 1;
    logic ready_val = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mdl_err(input logic [1:0] code);
        err_pend      = 1;
        err_pend_code = code;
        in_frame      = 0;
    endtask

    always @(negedge clk) begin
        logic [7:0] b;
        logic [7:0] x;
        bit         p;
        bit         dr;
        if (Reset) begin
            chk("rst_rd_uart",   32'(rd_uart),   32'(0));
            chk("rst_m_valid",   32'(m_valid),   32'(0));
            chk("rst_m_last",    32'(m_last),    32'(0));
            chk("rst_m_data",    32'(m_data),    32'(0));
            chk("rst_frame_len", 32'(frame_len), 32'(0));
            chk("rst_err_valid", 32'(err_valid), 32'(0));
            chk("rst_err_code",  32'(err_code),  32'(0));
            in_frame = 0;
            cur.delete();
            drain_q.delete();
            exp_len  = '0;
            err_pend = 0;
            since    = 0;
        end else begin
            dr = drain_q.size() > 0;
            chk("rd_uart", 32'(rd_uart), 32'(!rx_empty && !dr));
            chk("m_valid", 32'(m_valid), 32'(dr));
            if (dr) begin
                chk("m_data", 32'(m_data), 32'(drain_q[0]));
                chk("m_last", 32'(m_last), 32'(drain_q.size() == 1));
            end
            chk("frame_len", 32'(frame_len), 32'(exp_len));
            chk("err_valid", 32'(err_valid), 32'(err_pend));
            if (err_pend) chk("err_code", 32'(err_code), 32'(err_pend_code));

            if (m_valid && m_ready) out_log.push_back({m_last, m_data});
            if (err_valid) begin
                err_log.push_back(err_code);
                err_cyc = cyc;
            end
            if (rd_uart) last_pop_edge = cyc + 1;

            // advance the model across the coming edge
            err_pend = 0;
            b = r_data;
            p = parity_err;
            if (dr) begin
                if (m_ready) void'(drain_q.pop_front());
            end else if (rd_uart) begin
                since = 0;
                if (!in_frame) begin
                    if (b == SOF_B) begin
                        in_frame = 1;
                        cur.delete();
                    end
                end else if (p) begin
                    mdl_err(2'(ERR_PARITY));
                end else if (cur.size() == 0) begin
                    if (b == 8'h00 || 32'(b) > MAX_LEN) begin
                        mdl_err(2'(ERR_LEN));
                    end else begin
                        lenv    = 32'(b);
                        exp_len = LEN_W'(b);
                        cur.push_back(b);
                    end
                end else if (32'(cur.size()) < lenv + 1) begin
                    cur.push_back(b);
                end else begin
                    x = 8'h00;
                    foreach (cur[i]) x ^= cur[i];
                    if (x == b) begin
                        drain_q.delete();
                        for (int i = 1; i < cur.size(); i++) drain_q.push_back(cur[i]);
                        in_frame = 0;
                    end else begin
                        mdl_err(2'(ERR_CHK));
                    end
                end
            end else if (in_frame) begin
                if (since == TO) mdl_err(2'(ERR_TIMEOUT));
                else since++;
            end
        end
    end

    task automatic drive();
        rx_empty   = (fifo.size() == 0);
        r_data     = rx_empty ? 8'h00 : fifo[0][7:0];
        parity_err = rx_empty ? 1'b0 : fifo[0][8];
    endtask

    task automatic tick();
        bit pf;
        @(negedge clk);
        pf = rd_uart;
        @(posedge clk);
        #1;
        if (pf && fifo.size() > 0) void'(fifo.pop_front());
        m_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
        drive();
    endtask

    task automatic run(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic push_seq(input logic [63:0] s, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) fifo.push_back({1'b0, s[8*(n-1-k) +: 8]});
        drive();
    endtask

    task automatic run_idle(input int unsigned budget);
        int unsigned quiet = 0;
        int unsigned k;
        for (k = 0; k < budget; k++) begin
            tick();
            if (fifo.size() == 0 && !m_valid) quiet++;
            else quiet = 0;
            if (quiet >= 4) break;
        end
        if (k == budget) chk("idle_budget", 32'(k), 32'(0));
    endtask

    task automatic wait_empty();
        int unsigned k;
        for (k = 0; k < 2000 && fifo.size() != 0; k++) tick();
        if (fifo.size() != 0) chk("fifo_drain_budget", 32'(fifo.size()), 32'(0));
    endtask

    function automatic logic [8:0] out_at(input int i);
        if (i < out_log.size()) return out_log[i];
        return 9'h1FF;
    endfunction

    function automatic logic [2:0] err_at(input int i);
        if (i < err_log.size()) return {1'b0, err_log[i]};
        return 3'b111;
    endfunction

    function automatic bit rnd_par();
        return $urandom_range(0, 24) == 0;
    endfunction

    task automatic clear_logs();
        out_log.delete();
        err_log.delete();
    endtask

    task automatic send_random_frame();
        logic [8:0]  fr[$];
        logic [7:0]  x;
        logic [7:0]  b;
        int unsigned kind, len, split;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            repeat ($urandom_range(1, 3)) fr.push_back({1'b0, 8'($urandom)});
        end else if (kind == 1) begin
            b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
            fr.push_back({1'b0, SOF_B});
            fr.push_back({1'b0, b});
        end else begin
            len = $urandom_range(1, MAX_LEN);
            x   = 8'(len);
            fr.push_back({1'b0, SOF_B});
            fr.push_back({rnd_par(), 8'(len)});
            repeat (len) begin
                b = 8'($urandom);
                x ^= b;
                fr.push_back({rnd_par(), b});
            end
            if (kind == 2) x ^= 8'(1 << $urandom_range(0, 7));
            fr.push_back({rnd_par(), x});
        end
        split = ($urandom_range(0, 5) == 0) ? $urandom_range(1, fr.size()) : fr.size();
        for (int i = 0; i < fr.size(); i++) begin
            if (i == split) begin
                wait_empty();
                run($urandom_range(0, 2 * TO));
            end
            fifo.push_back(fr[i]);
            drive();
        end
        run($urandom_range(0, 20));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        drive();
        repeat (3) @(posedge clk);
        #1;
        push_seq(64'h5A, 1);
        #1;
        chk("reset_pop_blocked", 32'(rd_uart), 32'(0));
        chk("reset_m_valid",     32'(m_valid), 32'(0));
        Reset = 1'b0;
        run(3);

        // good frame
        clear_logs();
        push_seq(64'hA5_03_11_22_33_03, 6);
        run_idle(60);
        chk("good_cnt",   32'(out_log.size()), 32'(3));
        chk("good_b0",    32'(out_at(0)), 32'(9'h011));
        chk("good_b1",    32'(out_at(1)), 32'(9'h022));
        chk("good_b2",    32'(out_at(2)), 32'(9'h133));
        chk("good_len",   32'(frame_len), 32'(3));
        chk("good_noerr", 32'(err_log.size()), 32'(0));

        // bad checksum, then a good frame
        clear_logs();
        push_seq(64'hA5_03_11_22_33_04, 6);
        push_seq(64'hA5_01_5A_5B, 4);
        run_idle(60);
        chk("badchk_errs", 32'(err_log.size()), 32'(1));
        chk("badchk_code", 32'(err_at(0)), 32'(1));
        chk("badchk_out",  32'(out_log.size()), 32'(1));
        chk("badchk_next", 32'(out_at(0)), 32'(9'h15A));

        // length errors and garbage before SOF
        clear_logs();
        push_seq(64'hA5_00_A5_11, 4);
        push_seq(64'h00_FF_A5_01_5A_5B, 6);
        run_idle(60);
        chk("len_errs",  32'(err_log.size()), 32'(2));
        chk("len_code0", 32'(err_at(0)), 32'(0));
        chk("len_code1", 32'(err_at(1)), 32'(0));
        chk("len_out",   32'(out_log.size()), 32'(1));
        chk("len_next",  32'(out_at(0)), 32'(9'h15A));

        // backpressure with a backlog in the FIFO
        clear_logs();
        ready_val = 1'b0;
        push_seq(64'hA5_03_11_22_33_03, 6);
        push_seq(64'hA5_01_77_76, 4);
        for (int i = 0; i < 20 && !m_valid; i++) tick();
        chk("bp_valid_seen", 32'(m_valid), 32'(1));
        repeat (5) begin
            tick();
            #2;
            chk("bp_hold_data",  32'(m_data),  32'(8'h11));
            chk("bp_hold_valid", 32'(m_valid), 32'(1));
            chk("bp_no_pop",     32'(rd_uart), 32'(0));
        end
        ready_val = 1'b1;
        run_idle(60);
        chk("bp_cnt", 32'(out_log.size()), 32'(4));
        chk("bp_b0",  32'(out_at(0)), 32'(9'h011));
        chk("bp_b1",  32'(out_at(1)), 32'(9'h022));
        chk("bp_b2",  32'(out_at(2)), 32'(9'h133));
        chk("bp_b3",  32'(out_at(3)), 32'(9'h177));

        // inter-byte timeout
        clear_logs();
        push_seq(64'hA5_02_11, 3);
        run(TO + 15);
        chk("to_errs",  32'(err_log.size()), 32'(1));
        chk("to_code",  32'(err_at(0)), 32'(3));
        chk("to_delay", 32'(err_cyc - last_pop_edge), 32'(TO + 1));

        // parity error on a payload byte
        clear_logs();
        push_seq(64'hA5_02, 2);
        fifo.push_back({1'b1, 8'h11});
        push_seq(64'h22_33, 2);
        push_seq(64'hA5_01_5A_5B, 4);
        run_idle(60);
        chk("par_errs", 32'(err_log.size()), 32'(1));
        chk("par_code", 32'(err_at(0)), 32'(2));
        chk("par_out",  32'(out_log.size()), 32'(1));
        chk("par_next", 32'(out_at(0)), 32'(9'h15A));

        // reset in the middle of a payload
        clear_logs();
        push_seq(64'hA5_04_01_02, 4);
        run(6);
        chk("mid_len", 32'(frame_len), 32'(4));
        Reset = 1'b1;
        #1;
        chk("mid_rst_len",  32'(frame_len), 32'(0));
        chk("mid_rst_err",  32'(err_valid), 32'(0));
        chk("mid_rst_pop",  32'(rd_uart),   32'(0));
        run(2);
        Reset = 1'b0;
        clear_logs();
        push_seq(64'hA5_02_10_20_32, 5);
        run_idle(60);
        chk("post_rst_cnt",   32'(out_log.size()), 32'(2));
        chk("post_rst_b0",    32'(out_at(0)), 32'(9'h010));
        chk("post_rst_b1",    32'(out_at(1)), 32'(9'h120));
        chk("post_rst_noerr", 32'(err_log.size()), 32'(0));

        // randomized traffic against the model
        ready_force = 0;
        repeat (80) send_random_frame();
        run_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

- Receive-side consumer that sits directly downstream of the UART top.
- Pops bytes from the UART RX FIFO using `rx_empty`, `r_data` and `rd_uart`, and parses them into framed packets:
  - start byte `SOF`
  - length byte `LEN`
  - `LEN` payload bytes
  - XOR checksum byte `CHK`
- Each frame is buffered internally. Payload bytes are released on a valid/ready stream only after the checksum passes; bad frames are dropped and reported as a one-cycle error pulse with a code.

## Interface

- One clock; reset is asynchronous and active-high.

Parameters:

- `DATA_W`, 8: byte width. Equals the UART `Data_bits - 1`.
- `MAX_LEN`, 16: maximum payload bytes per frame; also the buffer depth.
- `SOF`, 8'hA5: start-of-frame byte.
- `TIMEOUT_CYCLES`, 230_000: inter-byte timeout, about 2 byte-times at 9600 baud with a 100 MHz `clk`.
- `LEN_W`, `$clog2(MAX_LEN+1)`: derived width of `frame_len`.
- `TO_W`, `$clog2(TIMEOUT_CYCLES+1)`: derived width of the timeout counter.

Ports:

- `clk` in 1: system clock.
- `Reset` in 1: asynchronous, active-high reset.
- `rx_empty` in 1: UART RX FIFO empty.
- `r_data` in `DATA_W`: FIFO head byte (first-word-fall-through).
- `parity_err` in 1: parity-error flag for the head byte, from the UART `incorrect_send`.
- `rd_uart` out 1: FIFO pop; the head byte is consumed at this edge.
- `m_data` out `DATA_W`: payload byte.
- `m_valid` out 1: payload byte valid.
- `m_last` out 1: final payload byte of the frame.
- `m_ready` in 1: downstream accepts the byte.
- `frame_len` out `LEN_W`: length of the frame being drained.
- `err_valid` out 1: one-cycle error pulse.
- `err_code` out 2: error code, qualified by `err_valid`:
  - 00 = LEN
  - 01 = CHK
  - 10 = PARITY
  - 11 = TIMEOUT

## Operation

- **States:** `HUNT`, `LEN`, `PAYLOAD`, `CHK`, `DRAIN`.
- **Pop rule:** `rd_uart = !rx_empty && state != DRAIN`. This is combinational, so at most one byte is popped per cycle.
- **HUNT:**
  - Popped byte == `SOF` → `LEN`.
  - Any other byte → discarded, stay in `HUNT`.
  - `parity_err` is ignored in this state.
- **LEN:**
  - LEN is 0 or greater than `MAX_LEN` → error LEN, go to `HUNT`.
  - Otherwise store `frame_len`, set checksum accumulator `acc = LEN`, clear `wr_ptr`, go to `PAYLOAD`.
- **PAYLOAD:**
  - Each byte is written to `buf[wr_ptr]`; then `wr_ptr++` and `acc ^= byte`.
  - When `wr_ptr` reaches `frame_len` → `CHK`.
- **CHK:**
  - Byte == `acc` → `DRAIN` with `rd_ptr = 0`.
  - Otherwise → error CHK, go to `HUNT`.
- **DRAIN:**
  - `m_valid = 1`, `m_data = buf[rd_ptr]`, `m_last = (rd_ptr == frame_len-1)`.
  - On `m_valid && m_ready`: `rd_ptr++`.
  - On the handshake of the `m_last` byte → `HUNT`.
- **Parity:** a byte popped with `parity_err = 1` in `LEN`, `PAYLOAD` or `CHK` → error PARITY, go to `HUNT`. The byte is consumed and its other checks are skipped.
- **Timeout:**
  - The counter runs in `LEN`, `PAYLOAD` and `CHK`, and clears on every pop and on every state entry.
  - When it reaches `TIMEOUT_CYCLES` → error TIMEOUT, go to `HUNT`.
  - The counter does not run in `HUNT` or `DRAIN`.
- **Simultaneous events:** a pop in the cycle the counter hits `TIMEOUT_CYCLES` takes priority and no timeout fires. Only one error is raised per byte, with priority PARITY > LEN/CHK.
- **Errors:** no payload byte of an erroneous frame ever appears on `m_*`.

## Timing

- **Reset values:** `rd_uart`, `m_valid`, `m_last`, `err_valid` = 0; `m_data`, `frame_len`, `err_code` = 0. State is `HUNT`; pointers, `acc` and timeout counter are 0.
- **Reset mid-frame:** the partial frame is lost; no error pulse is issued.
- **Error reporting:** `err_valid` is registered and pulses for exactly one cycle in the cycle after the offending pop or the timeout.
- **Drain latency:** the `CHK` byte is popped at edge N; `m_valid` is 1 from cycle N+1.
- **Back-to-back input:** with a continuously non-empty FIFO, a frame of length L is consumed in L+3 consecutive cycles (`SOF`, `LEN`, L payload bytes, `CHK`).
- **Stall behaviour:** while `m_ready` = 0, `m_data`, `m_last` and `m_valid` hold. No pops occur during `DRAIN`; the FIFO absorbs the backlog.
- **Width rules:** `acc` is `DATA_W` bits. `wr_ptr` and `rd_ptr` are `LEN_W` bits and never wrap, since they are bounded by `frame_len` ≤ `MAX_LEN`.

## Structure

- **Shared package `uart_pkg`:**
  - state enum `parser_state_t`
  - `err_code_t` enum (`ERR_LEN`, `ERR_CHK`, `ERR_PARITY`, `ERR_TIMEOUT`)
  - default `SOF` constant
- **Sub-module `frame_buf`:** `MAX_LEN` × `DATA_W` register array with a synchronous write port and a combinational read port. All other logic lives in `uart_frame_parser`.

## Test plan

- **Good frame:** A5 03 11 22 33 03 → `m_data` 11, 22, 33, with `m_last` on 33; `frame_len` = 3; no `err_valid`.
- **Bad checksum:** A5 03 11 22 33 04 → `err_valid` with code 01; `m_valid` never asserts. A following frame A5 01 5A 5B outputs 5A.
- **Length errors and garbage before SOF:**
  - A5 00 → LEN error; A5 11 (17) → LEN error.
  - 00 FF A5 01 5A 5B → 00 and FF are silently discarded, then 5A is output.
- **Backpressure:** good frame with `m_ready` = 0 for 5 cycles → `m_data` stable throughout; `rd_uart` stays 0 despite a non-empty FIFO; all bytes are delivered in order.
- **Timeout and parity:**
  - A5 02 11, then idle → TIMEOUT error exactly `TIMEOUT_CYCLES` cycles after the last pop.
  - A `PAYLOAD` byte with `parity_err` = 1 → PARITY error and return to `HUNT`.
- **Reset mid-PAYLOAD:** assert `Reset` mid-frame → all outputs go to 0 immediately; a subsequent good frame parses correctly.
